poly_term_differentiator: RTL



---
 rtl/poly_term_differentiator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/poly_term_differentiator.sv
// Polynomial term differentiator front-end.
// Takes one (coef, exp) term per input handshake and emits (coef*exp, exp-1).
// The product is formed by a shift-add loop that consumes one exponent bit
// per cycle, so every non-constant term spends exactly EXP_W cycles in MUL.
// Constant terms are dropped. A constant term that carries the last flag
// becomes a zero-valued "flush" beat, so the polynomial framing still
// reaches the downstream stage.
//
// Handshake rules (both ports): a beat transfers on a rising edge where
// valid && ready. A producer holds its valid signal and its payload stable
// until the beat transfers. in_ready depends only on the FSM state and
// never on in_valid.
module poly_term_differentiator #(
   parameter int COEF_W = 8,
   parameter int EXP_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [COEF_W-1:0]         in_coef,
   input  logic [EXP_W-1:0]          in_exp,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COEF_W+EXP_W-1:0]   out_coef,
   output logic [EXP_W-1:0]          out_exp,
   output logic                      out_last,
   output logic                      poly_done,
   output logic [EXP_W+3:0]          term_count
);

   localparam int OUT_W = COEF_W + EXP_W;
   localparam int CNT_W = EXP_W + 4;
   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] EMIT = 2'd2;

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_W - 1);
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]        state;
   logic [COEF_W-1:0] coef_r;
   logic [EXP_W-1:0]  exp_r;
   logic              last_r;
   logic [OUT_W-1:0]  acc;
   logic [IDX_W-1:0]  idx;
   logic              flush_r;   // current EMIT beat is a framing-only flush
   logic              new_poly;  // next accepted term starts a new polynomial

   logic [OUT_W-1:0]  addend;
   logic [OUT_W-1:0]  acc_next;
   logic              idx_last;

   // Handshake outputs are decoded straight from the state register.
   // in_ready is also held low while reset is asserted.
   always_comb begin
      in_ready  = (state == IDLE) && rst_n;
      out_valid = (state == EMIT);
   end

   // One shift-add step: add coef << idx when exponent bit idx is set.
   always_comb begin
      addend   = '0;
      if (exp_r[idx]) addend = OUT_W'(coef_r) << idx;
      acc_next = acc + addend;
      idx_last = (idx == IDX_LAST);
   end

   // Main FSM, datapath registers, framing and term counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         coef_r     <= '0;
         exp_r      <= '0;
         last_r     <= 1'b0;
         acc        <= '0;
         idx        <= '0;
         flush_r    <= 1'b0;
         new_poly   <= 1'b1;
         out_coef   <= '0;
         out_exp    <= '0;
         out_last   <= 1'b0;
         poly_done  <= 1'b0;
         term_count <= '0;
      end else begin
         poly_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (new_poly) begin
                     term_count <= '0;
                     new_poly   <= 1'b0;
                  end
                  if (in_exp != '0) begin
                     coef_r <= in_coef;
                     exp_r  <= in_exp;
                     last_r <= in_last;
                     acc    <= '0;
                     idx    <= '0;
                     state  <= MUL;
                  end else if (in_last) begin
                     out_coef <= '0;
                     out_exp  <= '0;
                     out_last <= 1'b1;
                     flush_r  <= 1'b1;
                     state    <= EMIT;
                  end
               end
            end
            MUL: begin
               acc <= acc_next;
               idx <= idx + IDX_ONE;
               if (idx_last) begin
                  out_coef <= acc_next;
                  out_exp  <= exp_r - EXP_ONE;
                  out_last <= last_r;
                  flush_r  <= 1'b0;
                  state    <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  state <= IDLE;
                  if (!flush_r) term_count <= term_count + CNT_ONE;
                  if (out_last) begin
                     poly_done <= 1'b1;
                     new_poly  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
